// File: rtl/spike_shift_pipe.sv
// spike_shift_pipe: per-channel signed spike-time shifter with clamp and spike-loss flags.
// Latency 2 cycles, 1 beat/cycle; in_ready follows out_ready combinationally (no skid buffer).
// SPIKE_SHIFT_STATS_EN adds stat_drop_cnt, a saturating count of emitted beats that lost spikes.
module spike_shift_pipe #(
   parameter int LEN           = 8,
   parameter int CH            = 4,
   parameter int MAX_SHIFT_MAG = 2,
   parameter int WRAP_AROUND   = 1,
   parameter int SW            = $clog2(MAX_SHIFT_MAG + 1) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*LEN-1:0]   in_spk,
   input  logic [CH*SW-1:0]    in_shift,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*LEN-1:0]   out_spk,
   output logic [CH-1:0]       out_drop,
`ifdef SPIKE_SHIFT_STATS_EN
   output logic [15:0]         stat_drop_cnt,
`endif
   output logic [CH-1:0]       out_clamp
);

   logic                s1_vld_q;
   logic                s2_vld_q;
   logic                s1_adv;
   logic                s2_adv;
   logic [CH*LEN-1:0]   s1_spk_q,   s1_spk_d;
   logic [CH*SW-1:0]    s1_sh_q,    s1_sh_d;
   logic [CH-1:0]       s1_clamp_q, s1_clamp_d;
   logic [CH*LEN-1:0]   s2_spk_q,   s2_spk_d;
   logic [CH-1:0]       s2_drop_q,  s2_drop_d;
   logic [CH-1:0]       s2_clamp_q, s2_clamp_d;
   int                  sh_in;
   int                  dst;

   assign s2_adv   = !s2_vld_q || out_ready;
   assign s1_adv   = !s1_vld_q || s2_adv;
   assign in_ready = s1_adv;

   // Stage 1 captures zeros for an empty slot so idle outputs come out zero downstream.
   always_comb begin
      s1_spk_d   = '0;
      s1_sh_d    = '0;
      s1_clamp_d = '0;
      sh_in      = 0;
      if (in_valid) begin
         s1_spk_d = in_spk;
         for (int c = 0; c < CH; c++) begin
            sh_in = int'($signed(in_shift[c*SW +: SW]));
            if (sh_in > MAX_SHIFT_MAG) begin
               s1_sh_d[c*SW +: SW] = SW'(MAX_SHIFT_MAG);
               s1_clamp_d[c]       = 1'b1;
            end else if (sh_in < -MAX_SHIFT_MAG) begin
               s1_sh_d[c*SW +: SW] = SW'(-MAX_SHIFT_MAG);
               s1_clamp_d[c]       = 1'b1;
            end else begin
               s1_sh_d[c*SW +: SW] = in_shift[c*SW +: SW];
            end
         end
      end
   end

   always_comb begin
      s2_spk_d   = '0;
      s2_drop_d  = '0;
      s2_clamp_d = s1_clamp_q;
      dst        = 0;
      for (int c = 0; c < CH; c++) begin
         for (int t = 0; t < LEN; t++) begin
            dst = t + int'($signed(s1_sh_q[c*SW +: SW]));
            if (s1_spk_q[c*LEN + t]) begin
               if (WRAP_AROUND != 0) begin
                  s2_spk_d[c*LEN + (((dst % LEN) + LEN) % LEN)] = 1'b1;
               end else if (dst >= 0 && dst < LEN) begin
                  s2_spk_d[c*LEN + dst] = 1'b1;
               end else begin
                  s2_drop_d[c] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_spk_q   <= '0;
         s1_sh_q    <= '0;
         s1_clamp_q <= '0;
         s2_vld_q   <= 1'b0;
         s2_spk_q   <= '0;
         s2_drop_q  <= '0;
         s2_clamp_q <= '0;
      end else begin
         if (s1_adv) begin
            s1_vld_q   <= in_valid;
            s1_spk_q   <= s1_spk_d;
            s1_sh_q    <= s1_sh_d;
            s1_clamp_q <= s1_clamp_d;
         end
         if (s2_adv) begin
            s2_vld_q   <= s1_vld_q;
            s2_spk_q   <= s2_spk_d;
            s2_drop_q  <= s2_drop_d;
            s2_clamp_q <= s2_clamp_d;
         end
      end
   end

   assign out_valid = s2_vld_q;
   assign out_spk   = s2_spk_q;
   assign out_drop  = s2_drop_q;
   assign out_clamp = s2_clamp_q;

`ifdef SPIKE_SHIFT_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (out_valid && out_ready && (|out_drop) && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule
